id_stage_rf: RTL and testbench
==============================

Name: id_stage_rf

Overview:
- Parametrised successor to the single-cycle decode/register-file block.
- Decodes a MIPS instruction, reads two source operands, and extends the immediate.
- Selects the destination register and write enable, then registers all results into an ID/EX pipeline register with valid/stall/flush control.
- Register-file writes come from an explicit write-back port, not from the instruction being decoded.

Parameters:
- DATA_W, 32, register and data width (≥16).
- NREG, 32, number of architectural registers (power of 2, ≥8).
- AW, $clog2(NREG), register address width; a derived localparam, not overridable.
- RA_IDX, NREG-1, link register index used by JAL.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- ins  in  32  instruction from IF.
- ins_valid  in  1  ins is a real instruction.
- stall  in  1  hold the ID/EX register (hazard unit).
- flush  in  1  bubble the ID/EX register (branch/jump redirect).
- wb_we  in  1  write-back enable.
- wb_addr  in  AW  write-back register index.
- wb_data  in  DATA_W  write-back data.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_rdata1  out  DATA_W  rs operand.
- ex_rdata2  out  DATA_W  rt operand.
- ex_imm  out  DATA_W  extended immediate.
- ex_dst  out  AW  destination register index.
- ex_reg_we  out  1  instruction writes a register.
- ex_op  out  6  opcode.
- ex_funct  out  6  funct field.
- ex_shamt  out  5  shift amount.
- ex_rs, ex_rt  out  AW each  source indices, for forwarding.
- dbg_addr  in  AW  debug read index.
- dbg_data  out  DATA_W  combinational read of register dbg_addr.

Behaviour:
- Reset (RST=0, asynchronous): all NREG registers and every ex_* output go to 0. Reset mid-operation discards in-flight state; first valid output appears 1 cycle after RST rises.
- Register 0 always reads 0; writes to index 0 are ignored.
- Register-file write happens on the CLK rising edge when wb_we=1 and wb_addr≠0. It is independent of ins, so J, JR, BEQ and SW never disturb the file.
- Reads are combinational on ins[25:21] and ins[20:16], truncated or zero-extended to AW.
- ID/EX latency is 1 cycle; outputs are registered. Priority per edge: flush > stall > load.
  - flush=1: ex_valid←0 and ex_reg_we←0; other fields don't-care, held at 0.
  - stall=1 with flush=0: all ex_* hold.
  - Otherwise: load decoded fields; ex_valid←ins_valid, ex_reg_we←reg_we & ins_valid.
- While stalled, the held operands must pick up matching write-backs. If stall=1, ex_valid=1, wb_we=1 and wb_addr equals ex_rs (or ex_rt) and is ≠0, then ex_rdata1 (or ex_rdata2) ← wb_data.
- Destination select:
  - JAL (0x03) → RA_IDX.
  - R-form (0x00) → rd.
  - All other writers → rt.
- reg_we=1 for:
  - R-form except JR (funct 0x08).
  - JAL.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI (0x08–0x0F).
  - LW (0x23).
- reg_we=0 for SW, BEQ, BNE, J and everything else. Any instruction with dst=0 forces reg_we=0.
- Immediate:
  - ANDI, ORI, XORI: zero-extend ins[15:0] to DATA_W.
  - LUI: {ins[15:0], 16'b0}, truncated to DATA_W.
  - Otherwise: sign-extend from ins[15].

Optional Feature:
- Macro ID_WB_BYPASS_EN, compiled in:
  - Same-cycle write-before-read. If wb_we=1, wb_addr≠0 and wb_addr equals the rs or rt index, the loaded operand is wb_data, not the stale file value.
  - dbg_data also bypasses.
- Macro absent:
  - Reads return the pre-edge file content.
  - The hazard unit must stall one extra cycle.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants (R_FORM, J, JAL, BEQ, BNE, ADDI…LUI, LW, SW).
  - Funct constants (JR, JALR).
  - A typedef for the decoded bundle (dst, reg_we, imm, op, funct, shamt, rs, rt).
- One sub-module, id_regfile: NREG×DATA_W storage with async reset, 2 read ports plus debug port, 1 write port, zero-register and optional bypass logic.
- Decode, immediate extension and the ID/EX register stay in id_stage_rf.

Test Plan:
- Reset, then write-back: release RST, write reg 10←5 and reg 0←0xFFFF. Next-cycle `add $t0,$t2,$zero` decodes ex_rdata1=5, ex_rdata2=0. dbg_addr=0 reads 0.
- Immediate extension: ANDI imm=0x8001 → ex_imm=0x00008001. ADDI imm=0x8001 → 0xFFFF8001. LUI 0x1234 → 0x12340000.
- Destination select: JAL → ex_dst=31, ex_reg_we=1. R-form rd=8 → ex_dst=8. LW rt=9 → ex_dst=9. SW, BEQ, JR, J → ex_reg_we=0, and no register changes.
- Stall and flush: stall for 2 cycles → ex_* unchanged. A write-back to ex_rs=10 of 0x77 during the stall → ex_rdata1=0x77. flush and stall together → ex_valid=0.
- Bypass: same-cycle wb_we to reg 17 with 2012 while decoding rs=17. With ID_WB_BYPASS_EN → ex_rdata1=2012. Without it → the old value.
- Async reset mid-stream: drop RST between edges → all ex_* and registers read 0 immediately, with no clock needed.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct constants, decoded bundle type and field decoder
package mips_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  // Width-independent view of one instruction; the stage narrows/widens it
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;       // rd for R-form, rt otherwise
    logic        dst_link;  // JAL: destination is the link register instead
    logic        reg_we;    // before the zero-destination squash
    logic [31:0] imm;       // immediate extended to 32 bits
    logic        imm_zx;    // widen imm with zeros rather than its sign bit
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d.op       = ins[31:26];
    d.rs       = ins[25:21];
    d.rt       = ins[20:16];
    d.shamt    = ins[10:6];
    d.funct    = ins[5:0];
    d.dst_link = (ins[31:26] == OP_JAL);
    d.dst      = (ins[31:26] == OP_R_FORM) ? ins[15:11] : ins[20:16];

    case (ins[31:26])
      OP_R_FORM: begin
        case (ins[5:0])
          FN_JR:   d.reg_we = 1'b0;
          FN_JALR: d.reg_we = 1'b1;
          default: d.reg_we = 1'b1;
        endcase
      end
      OP_JAL, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: d.reg_we = 1'b1;
      OP_J, OP_BEQ, OP_BNE, OP_SW:             d.reg_we = 1'b0;
      default:                                 d.reg_we = 1'b0;
    endcase

    case (ins[31:26])
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.imm    = {16'h0000, ins[15:0]};
        d.imm_zx = 1'b1;
      end
      OP_LUI: begin
        d.imm    = {ins[15:0], 16'h0000};
        d.imm_zx = 1'b1;
      end
      default: begin
        d.imm    = {{16{ins[15]}}, ins[15:0]};
        d.imm_zx = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - NREG x DATA_W register file, 2 read + debug port, 1 write port; ID_WB_BYPASS_EN adds write-before-read
module id_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  input  logic [AW-1:0]     i_dbg_addr,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  // Storage: every entry clears on reset; index 0 is never written
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: index 0 hard-wired to zero, optional same-cycle forwarding of the write
  always_comb begin
    o_rdata1   = (i_raddr1 == '0)   ? '0 : r_regs[i_raddr1];
    o_rdata2   = (i_raddr2 == '0)   ? '0 : r_regs[i_raddr2];
    o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
`ifdef ID_WB_BYPASS_EN
    if (w_wr && (i_waddr == i_raddr1))   o_rdata1   = i_wdata;
    if (w_wr && (i_waddr == i_raddr2))   o_rdata2   = i_wdata;
    if (w_wr && (i_waddr == i_dbg_addr)) o_dbg_data = i_wdata;
`endif
  end

endmodule

// File: rtl/id_stage_rf.sv
// rtl/id_stage_rf.sv - MIPS decode, operand read, immediate extend and ID/EX register; ID_WB_BYPASS_EN enables write-before-read
module id_stage_rf
  import mips_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 32,
  parameter  int RA_IDX = NREG - 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       ins,
  input  logic              ins_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [AW-1:0]     ex_dst,
  output logic              ex_reg_we,
  output logic [5:0]        ex_op,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_shamt,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  dec_t              w_dec;
  logic [AW-1:0]     w_rs;
  logic [AW-1:0]     w_rt;
  logic [AW-1:0]     w_dst;
  logic              w_reg_we;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic              w_wb_hit;

  logic              r_valid;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] r_imm;
  logic [AW-1:0]     r_dst;
  logic              r_reg_we;
  logic [5:0]        r_op;
  logic [5:0]        r_funct;
  logic [4:0]        r_shamt;
  logic [AW-1:0]     r_rs;
  logic [AW-1:0]     r_rt;

  assign w_dec = decode(ins);

  // Fit instruction fields to the configured index/data widths
  always_comb begin
    w_rs     = AW'(w_dec.rs);
    w_rt     = AW'(w_dec.rt);
    w_dst    = w_dec.dst_link ? AW'(RA_IDX) : AW'(w_dec.dst);
    w_reg_we = w_dec.reg_we && (w_dst != '0);
    w_imm    = w_dec.imm_zx ? DATA_W'(w_dec.imm) : DATA_W'($signed(w_dec.imm));
  end

  id_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regfile (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_raddr1   (w_rs),
    .i_raddr2   (w_rt),
    .i_dbg_addr (dbg_addr),
    .i_we       (wb_we),
    .i_waddr    (wb_addr),
    .i_wdata    (wb_data),
    .o_rdata1   (w_rdata1),
    .o_rdata2   (w_rdata2),
    .o_dbg_data (dbg_data)
  );

  // A held instruction keeps its operands current with write-backs that land while stalled
  assign w_wb_hit = r_valid && wb_we && (wb_addr != '0);

  // ID/EX register: flush beats stall beats load
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid  <= 1'b0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_dst    <= '0;
      r_reg_we <= 1'b0;
      r_op     <= '0;
      r_funct  <= '0;
      r_shamt  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_dst    <= '0;
      r_reg_we <= 1'b0;
      r_op     <= '0;
      r_funct  <= '0;
      r_shamt  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
    end else if (stall) begin
      if (w_wb_hit && (wb_addr == r_rs)) r_rdata1 <= wb_data;
      if (w_wb_hit && (wb_addr == r_rt)) r_rdata2 <= wb_data;
    end else begin
      r_valid  <= ins_valid;
      r_rdata1 <= w_rdata1;
      r_rdata2 <= w_rdata2;
      r_imm    <= w_imm;
      r_dst    <= w_dst;
      r_reg_we <= w_reg_we && ins_valid;
      r_op     <= w_dec.op;
      r_funct  <= w_dec.funct;
      r_shamt  <= w_dec.shamt;
      r_rs     <= w_rs;
      r_rt     <= w_rt;
    end
  end

  assign ex_valid  = r_valid;
  assign ex_rdata1 = r_rdata1;
  assign ex_rdata2 = r_rdata2;
  assign ex_imm    = r_imm;
  assign ex_dst    = r_dst;
  assign ex_reg_we = r_reg_we;
  assign ex_op     = r_op;
  assign ex_funct  = r_funct;
  assign ex_shamt  = r_shamt;
  assign ex_rs     = r_rs;
  assign ex_rt     = r_rt;

endmodule

// File: tb/tb_id_stage_rf.sv
// tb/tb_id_stage_rf.sv - directed and randomized check of id_stage_rf against a behavioural model
module tb_id_stage_rf;

  logic        CLK;
  logic        RST;
  logic [31:0] ins;
  logic        ins_valid;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_dst;
  logic        ex_reg_we;
  logic [5:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_total = 0;
  int n_bad   = 0;

  // reference state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_r1;
  logic [31:0] m_r2;
  logic [31:0] m_imm;
  logic [4:0]  m_dst;
  logic        m_we;
  logic [5:0]  m_op;
  logic [5:0]  m_funct;
  logic [4:0]  m_shamt;
  logic [4:0]  m_rs;
  logic [4:0]  m_rt;

  id_stage_rf dut (
    .CLK       (CLK),
    .RST       (RST),
    .ins       (ins),
    .ins_valid (ins_valid),
    .stall     (stall),
    .flush     (flush),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .ex_rdata1 (ex_rdata1),
    .ex_rdata2 (ex_rdata2),
    .ex_imm    (ex_imm),
    .ex_dst    (ex_dst),
    .ex_reg_we (ex_reg_we),
    .ex_op     (ex_op),
    .ex_funct  (ex_funct),
    .ex_shamt  (ex_shamt),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_dst = '0; m_we = 1'b0;
    m_op = '0; m_funct = '0; m_shamt = '0; m_rs = '0; m_rt = '0;
  endtask

  function automatic logic [31:0] model_dbg();
    logic [31:0] v;
    v = m_regs[dbg_addr];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == dbg_addr) v = wb_data;
`endif
    return v;
  endfunction

  // One clock edge of the architectural behaviour, using the current inputs
  task automatic model_edge();
    int          op;
    int          fn;
    int          rs;
    int          rt;
    int          rd;
    int          dst;
    bit          writes;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    op = int'(ins[31:26]);
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    fn = int'(ins[5:0]);
    a  = m_regs[rs];
    b  = m_regs[rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && int'(wb_addr) == rs) a = wb_data;
    if (wb_we && wb_addr != 5'd0 && int'(wb_addr) == rt) b = wb_data;
`endif
    if (op == 12 || op == 13 || op == 14) imm = 32'(ins[15:0]);
    else if (op == 15)                    imm = 32'(ins[15:0]) << 16;
    else                                  imm = 32'(signed'(ins[15:0]));
    writes = (op == 0 && fn != 8) || op == 3 || (op >= 8 && op <= 15) || op == 35;
    dst = (op == 3) ? 31 : (op == 0) ? rd : rt;
    if (dst == 0) writes = 1'b0;

    if (flush) begin
      m_valid = 1'b0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_dst = '0; m_we = 1'b0;
      m_op = '0; m_funct = '0; m_shamt = '0; m_rs = '0; m_rt = '0;
    end else if (stall) begin
      if (m_valid && wb_we && wb_addr != 5'd0) begin
        if (wb_addr == m_rs) m_r1 = wb_data;
        if (wb_addr == m_rt) m_r2 = wb_data;
      end
    end else begin
      m_valid = ins_valid;
      m_r1    = a;
      m_r2    = b;
      m_imm   = imm;
      m_dst   = 5'(dst);
      m_we    = writes && ins_valid;
      m_op    = 6'(op);
      m_funct = 6'(fn);
      m_shamt = ins[10:6];
      m_rs    = 5'(rs);
      m_rt    = 5'(rt);
    end
    if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
  endtask

  task automatic check_ex();
    check("ex_valid",  32'(ex_valid),  32'(m_valid));
    check("ex_rdata1", ex_rdata1,      m_r1);
    check("ex_rdata2", ex_rdata2,      m_r2);
    check("ex_imm",    ex_imm,         m_imm);
    check("ex_dst",    32'(ex_dst),    32'(m_dst));
    check("ex_reg_we", 32'(ex_reg_we), 32'(m_we));
    check("ex_op",     32'(ex_op),     32'(m_op));
    check("ex_funct",  32'(ex_funct),  32'(m_funct));
    check("ex_shamt",  32'(ex_shamt),  32'(m_shamt));
    check("ex_rs",     32'(ex_rs),     32'(m_rs));
    check("ex_rt",     32'(ex_rt),     32'(m_rt));
  endtask

  // Called just after a rising edge with inputs set; returns just after the next one
  task automatic step();
    @(negedge CLK);
    check("dbg_data", dbg_data, model_dbg());
    model_edge();
    @(posedge CLK);
    #1;
    check_ex();
  endtask

  task automatic quiet();
    ins = 32'h0; ins_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  task automatic randomize_inputs();
    logic [5:0] op;
    logic [5:0] fn;
    int         pick;
    pick = int'($urandom_range(0, 17));
    case (pick)
      0, 1, 2: op = 6'h00;
      3:  op = 6'h02;
      4:  op = 6'h03;
      5:  op = 6'h04;
      6:  op = 6'h05;
      7:  op = 6'h23;
      8:  op = 6'h2B;
      9:  op = 6'($urandom);
      default: op = 6'($urandom_range(8, 15));
    endcase
    case ($urandom_range(0, 3))
      0: fn = 6'h08;
      1: fn = 6'h09;
      2: fn = 6'h20;
      default: fn = 6'($urandom);
    endcase
    ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), fn};
    if ($urandom_range(0, 3) == 0) ins[25:16] = 10'($urandom);
    ins_valid = ($urandom_range(0, 4) != 0);
    stall     = ($urandom_range(0, 3) == 0);
    flush     = ($urandom_range(0, 9) == 0);
    wb_we     = ($urandom_range(0, 1) == 1);
    wb_addr   = ($urandom_range(0, 2) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    wb_data   = $urandom;
    dbg_addr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
  endtask

  initial begin
    logic [31:0] exp_byp;
    RST = 1'b0;
    dbg_addr = 5'd0;
    quiet();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid",  32'(ex_valid),  32'd0);
    check("rst_rdata1", ex_rdata1,      32'd0);
    check("rst_imm",    ex_imm,         32'd0);
    check("rst_reg_we", 32'(ex_reg_we), 32'd0);
    check("rst_dbg",    dbg_data,       32'd0);
    RST = 1'b1;

    // write-back, then read through an R-form add
    wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'd5;
    step();
    wb_addr = 5'd0; wb_data = 32'h0000FFFF;
    step();
    quiet();
    ins = r_ins(10, 0, 8, 0, 6'h20); ins_valid = 1'b1; dbg_addr = 5'd0;
    step();
    check("add_rs",    ex_rdata1,   32'd5);
    check("add_rt",    ex_rdata2,   32'd0);
    check("add_dst",   32'(ex_dst), 32'd8);
    check("dbg_zero",  dbg_data,    32'd0);

    // immediate extension
    ins = i_ins(6'h0C, 1, 2, 16'h8001);
    step();
    check("andi_imm", ex_imm, 32'h00008001);
    ins = i_ins(6'h08, 1, 2, 16'h8001);
    step();
    check("addi_imm", ex_imm, 32'hFFFF8001);
    ins = i_ins(6'h0F, 0, 3, 16'h1234);
    step();
    check("lui_imm",  ex_imm, 32'h12340000);

    // destination select and non-writers
    ins = {6'h03, 26'h0000123};
    step();
    check("jal_dst", 32'(ex_dst),    32'd31);
    check("jal_we",  32'(ex_reg_we), 32'd1);
    ins = i_ins(6'h23, 1, 9, 4);
    step();
    check("lw_dst",  32'(ex_dst),    32'd9);
    ins = i_ins(6'h2B, 10, 9, 4);
    step();
    check("sw_we",   32'(ex_reg_we), 32'd0);
    ins = i_ins(6'h04, 10, 9, 4);
    step();
    check("beq_we",  32'(ex_reg_we), 32'd0);
    ins = r_ins(10, 0, 31, 0, 6'h08);
    step();
    check("jr_we",   32'(ex_reg_we), 32'd0);
    ins = {6'h02, 26'h00000A0};
    dbg_addr = 5'd10;
    step();
    check("j_we",    32'(ex_reg_we), 32'd0);
    check("reg10_kept", dbg_data,    32'd5);

    // stall hold, stalled write-back pickup, flush over stall
    ins = r_ins(10, 9, 8, 3, 6'h20);
    step();
    stall = 1'b1;
    ins = i_ins(6'h0D, 4, 5, 16'hBEEF);
    step();
    wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h77;
    step();
    check("stall_wb_rs", ex_rdata1,      32'h77);
    check("stall_op",    32'(ex_op),     32'd0);
    check("stall_shamt", 32'(ex_shamt),  32'd3);
    wb_we = 1'b0;
    flush = 1'b1;
    step();
    check("flush_valid", 32'(ex_valid),  32'd0);
    check("flush_we",    32'(ex_reg_we), 32'd0);
    quiet();

    // same-cycle write-back versus read
    wb_we = 1'b1; wb_addr = 5'd17; wb_data = 32'hAAAA;
    step();
    ins = r_ins(17, 0, 8, 0, 6'h20); ins_valid = 1'b1;
    wb_data = 32'd2012;
    step();
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'd2012;
`else
    exp_byp = 32'hAAAA;
`endif
    check("bypass_rs", ex_rdata1, exp_byp);
    quiet();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      step();
    end

    // asynchronous reset between edges
    quiet();
    ins = i_ins(6'h08, 10, 7, 16'h8123); ins_valid = 1'b1;
    step();
    wb_we = 1'b0;
    #2;
    RST = 1'b0;
    dbg_addr = 5'd10;
    #1;
    check("arst_valid",  32'(ex_valid), 32'd0);
    check("arst_rdata1", ex_rdata1,     32'd0);
    check("arst_imm",    ex_imm,        32'd0);
    check("arst_dst",    32'(ex_dst),   32'd0);
    check("arst_op",     32'(ex_op),    32'd0);
    check("arst_dbg",    dbg_data,      32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int n = 0; n < 40; n++) begin
      randomize_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
